// File: rtl/systolic_gemm_tile.sv
// Output-stationary ROWS x COLS multiply-accumulate tile with input skew, run FSM and row-serial drain.
// Define SATURATE_EN to clamp accumulators to the AW range instead of wrapping modulo 2^AW.
module systolic_gemm_tile #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 8,
  parameter int AW   = 32,
  parameter int KW   = 16,
  localparam int IW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [KW-1:0]      k_len,
  input  logic               signed_mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ROWS*DW-1:0] in_w,
  input  logic [COLS*DW-1:0] in_a,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COLS*AW-1:0] out_row,
  output logic [IW-1:0]      out_idx,
  output logic               busy,
  output logic               done
);

  localparam int FLUSH_N = ROWS + COLS - 2;
  localparam int FW      = (FLUSH_N > 0) ? $clog2(FLUSH_N + 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] klen_q, klen_d;
  logic [KW-1:0] beat_q, beat_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [IW-1:0] row_q, row_d;
  logic          sgn_q, sgn_d;
  logic          done_q, done_d;

  logic step;
  logic clear;
  logic [ROWS*DW-1:0]      w_inj, w_left;
  logic [COLS*DW-1:0]      a_inj, a_top;
  logic [ROWS*COLS*DW-1:0] w_chain, a_chain;
  logic [ROWS*COLS*AW-1:0] acc_all;

  always_comb begin
    state_d = state_q;
    klen_d  = klen_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    row_d   = row_q;
    sgn_d   = sgn_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          klen_d  = k_len;
          sgn_d   = signed_mode;
          beat_d  = '0;
          flush_d = '0;
          row_d   = '0;
          state_d = (k_len != '0) ? S_LOAD : S_DRAIN;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          beat_d = beat_q + KW'(1);
          if (beat_q == klen_q - KW'(1)) begin
            state_d = (FLUSH_N > 0) ? S_FLUSH : S_DRAIN;
          end
        end
      end
      S_FLUSH: begin
        flush_d = flush_q + FW'(1);
        if (flush_q == FW'(FLUSH_N - 1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (row_q == IW'(ROWS - 1)) begin
            state_d = S_IDLE;
            row_d   = '0;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + IW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      klen_q  <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
      sgn_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      klen_q  <= klen_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
      row_q   <= row_d;
      sgn_q   <= sgn_d;
      done_q  <= done_d;
    end
  end

  // The whole array and skew chain advance together; bubbles freeze everything.
  assign step  = ((state_q == S_LOAD) && in_valid) || (state_q == S_FLUSH);
  assign clear = (state_q == S_IDLE) && start;
  assign w_inj = (state_q == S_LOAD) ? in_w : '0;
  assign a_inj = (state_q == S_LOAD) ? in_a : '0;

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_DRAIN);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign out_idx   = row_q;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_wskew
    if (gi == 0) begin : g_direct
      assign w_left[gi*DW +: DW] = w_inj[gi*DW +: DW];
    end else begin : g_delay
      logic [DW-1:0] sk_q [gi];
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          for (int s = 0; s < gi; s++) sk_q[s] <= '0;
        end else if (step) begin
          sk_q[0] <= w_inj[gi*DW +: DW];
          for (int s = 1; s < gi; s++) sk_q[s] <= sk_q[s-1];
        end
      end
      assign w_left[gi*DW +: DW] = sk_q[gi-1];
    end
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_askew
    if (gj == 0) begin : g_direct
      assign a_top[gj*DW +: DW] = a_inj[gj*DW +: DW];
    end else begin : g_delay
      logic [DW-1:0] sk_q [gj];
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          for (int s = 0; s < gj; s++) sk_q[s] <= '0;
        end else if (step) begin
          sk_q[0] <= a_inj[gj*DW +: DW];
          for (int s = 1; s < gj; s++) sk_q[s] <= sk_q[s-1];
        end
      end
      assign a_top[gj*DW +: DW] = sk_q[gj-1];
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      localparam int P = gi*COLS + gj;
      logic [DW-1:0]        w_in, a_in;
      logic signed [AW-1:0] w_ext, a_ext, prod;
      logic [AW-1:0]        acc_q, acc_d;

      // Each PE owns the hop register feeding it from its left/upper neighbour.
      if (gj == 0) begin : g_wl
        assign w_chain[P*DW +: DW] = w_left[gi*DW +: DW];
      end else begin : g_wh
        logic [DW-1:0] hop_q;
        always_ff @(posedge clk) begin
          if (rst || clear) hop_q <= '0;
          else if (step)    hop_q <= w_chain[(P-1)*DW +: DW];
        end
        assign w_chain[P*DW +: DW] = hop_q;
      end

      if (gi == 0) begin : g_at
        assign a_chain[P*DW +: DW] = a_top[gj*DW +: DW];
      end else begin : g_ah
        logic [DW-1:0] hop_q;
        always_ff @(posedge clk) begin
          if (rst || clear) hop_q <= '0;
          else if (step)    hop_q <= a_chain[(P-COLS)*DW +: DW];
        end
        assign a_chain[P*DW +: DW] = hop_q;
      end

      assign w_in  = w_chain[P*DW +: DW];
      assign a_in  = a_chain[P*DW +: DW];
      assign w_ext = AW'($signed({sgn_q & w_in[DW-1], w_in}));
      assign a_ext = AW'($signed({sgn_q & a_in[DW-1], a_in}));
      assign prod  = w_ext * a_ext;

`ifdef SATURATE_EN
      logic          sat_q, sat_d;
      logic [AW:0]   sum;
      always_comb begin
        sum   = sgn_q ? ({acc_q[AW-1], acc_q} + {prod[AW-1], prod})
                      : ({1'b0, acc_q} + {1'b0, prod});
        acc_d = sum[AW-1:0];
        sat_d = sat_q;
        if (sat_q) begin
          acc_d = acc_q;
        end else if (sgn_q && (sum[AW] != sum[AW-1])) begin
          acc_d = {sum[AW], {(AW-1){~sum[AW]}}};
          sat_d = 1'b1;
        end else if (!sgn_q && sum[AW]) begin
          acc_d = '1;
          sat_d = 1'b1;
        end
      end
      always_ff @(posedge clk) begin
        if (rst || clear) sat_q <= 1'b0;
        else if (step)    sat_q <= sat_d;
      end
`else
      assign acc_d = acc_q + prod;
`endif

      always_ff @(posedge clk) begin
        if (rst || clear) acc_q <= '0;
        else if (step)    acc_q <= acc_d;
      end
      assign acc_all[P*AW +: AW] = acc_q;
    end
  end

  always_comb begin
    out_row = '0;
    if (state_q == S_DRAIN) begin
      for (int r = 0; r < ROWS; r++) begin
        if (row_q == IW'(r)) out_row = acc_all[r*COLS*AW +: COLS*AW];
      end
    end
  end

endmodule

// File: tb/tb_systolic_gemm_tile.sv
// Self-checking bench for systolic_gemm_tile: directed and random GEMM runs against a plain-arithmetic model.
module tb_systolic_gemm_tile;

  localparam int R       = 4;
  localparam int C       = 4;
  localparam int DW      = 8;
  localparam int AW      = 16;
  localparam int KW      = 16;
  localparam int IW      = 2;
  localparam int MAXK    = 16;
  localparam int FLUSH_N = R + C - 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            signed_mode;
  logic            in_valid;
  logic            in_ready;
  logic [R*DW-1:0] in_w;
  logic [C*DW-1:0] in_a;
  logic            out_valid;
  logic            out_ready;
  logic [C*AW-1:0] out_row;
  logic [IW-1:0]   out_idx;
  logic            busy;
  logic            done;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] w_mem   [MAXK][R];
  logic [DW-1:0] a_mem   [MAXK][C];
  logic [AW-1:0] exp_acc [R][C];

  systolic_gemm_tile #(.ROWS(R), .COLS(C), .DW(DW), .AW(AW), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w), .in_a(in_a),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_idx(out_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic longint opnd(input logic [DW-1:0] v, input bit sgn);
    if (sgn) return longint'($signed(v));
    return longint'(v);
  endfunction

  // acc[i][j] = sum_k w_k[i]*a_k[j], wrapped or clamped (sticky) to AW bits
  task automatic compute_expected(input int k, input bit sgn);
    longint acc;
`ifdef SATURATE_EN
    longint maxv, minv;
    bit     sat;
    maxv = sgn ? (64'sd1 <<< (AW-1)) - 1 : (64'sd1 <<< AW) - 1;
    minv = sgn ? -(64'sd1 <<< (AW-1)) : 64'sd0;
`endif
    for (int i = 0; i < R; i++) begin
      for (int j = 0; j < C; j++) begin
        acc = 0;
`ifdef SATURATE_EN
        sat = 1'b0;
`endif
        for (int kk = 0; kk < k; kk++) begin
`ifdef SATURATE_EN
          if (!sat) begin
            acc = acc + opnd(w_mem[kk][i], sgn) * opnd(a_mem[kk][j], sgn);
            if (acc > maxv) begin acc = maxv; sat = 1'b1; end
            else if (acc < minv) begin acc = minv; sat = 1'b1; end
          end
`else
          acc = acc + opnd(w_mem[kk][i], sgn) * opnd(a_mem[kk][j], sgn);
`endif
        end
        exp_acc[i][j] = acc[AW-1:0];
      end
    end
  endtask

  task automatic fill_const(input int k, input logic [DW-1:0] wv, input logic [DW-1:0] av);
    for (int kk = 0; kk < MAXK; kk++) begin
      for (int i = 0; i < R; i++) w_mem[kk][i] = (kk < k) ? wv : 8'h00;
      for (int j = 0; j < C; j++) a_mem[kk][j] = (kk < k) ? av : 8'h00;
    end
  endtask

  task automatic fill_identity();
    fill_const(0, 8'h00, 8'h00);
    w_mem[0][0] = 8'd1;
    w_mem[1][1] = 8'd1;
    a_mem[0][0] = 8'd5;  a_mem[0][1] = 8'd6;  a_mem[0][2] = 8'd9;  a_mem[0][3] = 8'd10;
    a_mem[1][0] = 8'd7;  a_mem[1][1] = 8'd8;  a_mem[1][2] = 8'd11; a_mem[1][3] = 8'd12;
  endtask

  task automatic fill_random(input int k);
    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < R; i++) w_mem[kk][i] = 8'($urandom());
      for (int j = 0; j < C; j++) a_mem[kk][j] = 8'($urandom());
    end
  endtask

  // Starts at the current negedge and returns at the negedge where done is observed.
  task automatic run_gemm(input string name, input int k, input bit sgn, input bit bub, input bit bp);
    int          cyc;
    int          b;
    int          bubbles;
    int          guard;
    logic [63:0] er;
    compute_expected(k, sgn);
    start       = 1'b1;
    k_len       = KW'(k);
    signed_mode = sgn;
    @(negedge clk);
    cyc         = 1;
    start       = 1'b0;
    k_len       = KW'($urandom());
    signed_mode = 1'($urandom());
    check({name, "/done_low_after_start"}, done, 0);
    check({name, "/busy"}, busy, 1);
    check({name, "/in_ready_first"}, in_ready, (k != 0));
    b = 0; bubbles = 0; guard = 0;
    while (b < k && guard < 4*MAXK) begin
      in_valid = bub ? ((cyc % 2) == 1) : 1'b1;
      if (in_valid) begin
        for (int i = 0; i < R; i++) in_w[i*DW +: DW] = w_mem[b][i];
        for (int j = 0; j < C; j++) in_a[j*DW +: DW] = a_mem[b][j];
      end else begin
        in_w = $urandom();
        in_a = $urandom();
      end
      check({name, "/in_ready_load"}, in_ready, 1);
      @(negedge clk);
      cyc++; guard++;
      if (in_valid) b++;
      else bubbles++;
    end
    in_valid = 1'b0;
    in_w = $urandom();
    in_a = $urandom();
    check({name, "/in_ready_after_last"}, in_ready, 0);
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      cyc++; guard++;
    end
    check({name, "/first_out_valid_cycle"}, cyc, (k == 0) ? 1 : 1 + k + FLUSH_N + bubbles);
    for (int r = 0; r < R; r++) begin
      er = '0;
      for (int j = 0; j < C; j++) er[j*AW +: AW] = exp_acc[r][j];
      if (bp && r == 0) begin
        for (int h = 0; h < 3; h++) begin
          out_ready = 1'b0;
          check($sformatf("%s/hold%0d_valid", name, h), out_valid, 1);
          check($sformatf("%s/hold%0d_idx", name, h), out_idx, 0);
          check($sformatf("%s/hold%0d_row", name, h), out_row, er);
          @(negedge clk);
        end
      end
      out_ready = 1'b1;
      check($sformatf("%s/row%0d_valid", name, r), out_valid, 1);
      check($sformatf("%s/row%0d_idx", name, r), out_idx, r);
      check($sformatf("%s/row%0d_data", name, r), out_row, er);
      check($sformatf("%s/row%0d_no_done", name, r), done, 0);
      @(negedge clk);
    end
    out_ready = 1'b0;
    check({name, "/done_pulse"}, done, 1);
    check({name, "/busy_end"}, busy, 0);
    check({name, "/out_valid_end"}, out_valid, 0);
    $display("run %s: k=%0d signed=%0d bubbles=%0d backpressure=%0d", name, k, sgn, bubbles, bp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; signed_mode = 1'b0;
    in_valid = 1'b0; in_w = '0; in_a = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset/in_ready", in_ready, 0);
    check("reset/out_valid", out_valid, 0);
    check("reset/out_row", out_row, 0);
    check("reset/out_idx", out_idx, 0);
    check("reset/busy", busy, 0);
    check("reset/done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    fill_identity();
    run_gemm("identity", 2, 1'b0, 1'b0, 1'b0);
    run_gemm("klen_zero", 0, 1'b0, 1'b0, 1'b0);
    fill_const(1, 8'hFF, 8'h80);
    run_gemm("neg_signed", 1, 1'b1, 1'b0, 1'b0);
    run_gemm("neg_unsigned", 1, 1'b0, 1'b0, 1'b0);
    fill_identity();
    run_gemm("bubbles", 2, 1'b0, 1'b1, 1'b0);
    run_gemm("backpressure", 2, 1'b0, 1'b0, 1'b1);
    fill_const(3, 8'h7F, 8'h7F);
    run_gemm("overflow", 3, 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 6; n++) begin
      int  k;
      bit  sgn, bub, bp;
      k   = $urandom_range(1, MAXK - 1);
      sgn = 1'($urandom());
      bub = 1'($urandom());
      bp  = 1'($urandom());
      fill_random(k);
      run_gemm($sformatf("random%0d", n), k, sgn, bub, bp);
    end

    // Reset in the middle of LOAD discards the run without a done pulse.
    fill_random(5);
    start = 1'b1; k_len = KW'(5); signed_mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      in_w = $urandom();
      in_a = $urandom();
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("midrst/busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst/in_ready", in_ready, 0);
    check("midrst/out_valid", out_valid, 0);
    check("midrst/out_row", out_row, 0);
    check("midrst/out_idx", out_idx, 0);
    check("midrst/busy", busy, 0);
    check("midrst/done", done, 0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("midrst/idle%0d_done", c), done, 0);
      check($sformatf("midrst/idle%0d_busy", c), busy, 0);
    end
    $display("run midrst: reset asserted after 2 of 5 beats");

    fill_random(4);
    run_gemm("after_reset", 4, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("final/done_single_pulse", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
